// File: rtl/wave_tone_generator.sv
// ============================================================================
// wave_tone_generator : DDS square/saw/triangle tone source, valid/ready out.
// Optional macro WAVE_TONE_OVERRUN_COUNT_EN adds a saturating overrun_count.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module wave_tone_generator #(
  parameter int CLK_FREQ_HZ    = 50000000,
  parameter int SAMPLE_FREQ_HZ = 48000,
  parameter int SAMPLE_WIDTH   = 16,
  parameter int VOLUME_WIDTH   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [3:0]              note,
  input  logic [2:0]              octave,
  input  logic [VOLUME_WIDTH-1:0] volume,
  input  logic [1:0]              wave_sel,
  input  logic                    source_ready,
  output logic [SAMPLE_WIDTH-1:0] source_data,
  output logic                    source_valid
`ifdef WAVE_TONE_OVERRUN_COUNT_EN
  ,
  output logic [15:0]             overrun_count
`endif
);

  localparam int c_sample_clk_count = (CLK_FREQ_HZ + SAMPLE_FREQ_HZ / 2) / SAMPLE_FREQ_HZ;
  localparam int c_cnt_w            = (c_sample_clk_count > 1) ? $clog2(c_sample_clk_count) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_sample_clk_count - 1);
  localparam logic signed [SAMPLE_WIDTH-1:0] c_sample_max = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
  localparam int c_prod_w = SAMPLE_WIDTH + VOLUME_WIDTH + 1;

  // Octave-0 increments: round(f0 * 2**32 / 48000); notes above B fall into the default.
  function automatic logic [31:0] base_inc(input logic [3:0] n);
    case (n)
      4'd0:    base_inc = 32'd1462973;
      4'd1:    base_inc = 32'd1549767;
      4'd2:    base_inc = 32'd1641930;
      4'd3:    base_inc = 32'd1740357;
      4'd4:    base_inc = 32'd1843257;
      4'd5:    base_inc = 32'd1953315;
      4'd6:    base_inc = 32'd2068743;
      4'd7:    base_inc = 32'd2192223;
      4'd8:    base_inc = 32'd2322861;
      4'd9:    base_inc = 32'd2460658;
      4'd10:   base_inc = 32'd2607403;
      default: base_inc = 32'd2762201;
    endcase
  endfunction

  logic [c_cnt_w-1:0]             count_q, count_d;
  logic [31:0]                    phase_q, phase_d;
  logic [SAMPLE_WIDTH-1:0]        data_q, data_d;
  logic                           valid_q, valid_d;
`ifdef WAVE_TONE_OVERRUN_COUNT_EN
  logic [15:0]                    overrun_count_q, overrun_count_d;
`endif

  logic                           tick;
  logic [31:0]                    inc;
  logic [SAMPLE_WIDTH-1:0]        tri_u, tri_t;
  logic signed [SAMPLE_WIDTH-1:0] raw;
  logic signed [c_prod_w-1:0]     raw_ext, vol_ext;
  logic [SAMPLE_WIDTH-1:0]        scaled;

  always_comb begin
    tick  = (count_q == c_cnt_last);
    inc   = base_inc(note) << octave;
    tri_u = phase_q[30:31-SAMPLE_WIDTH];
    tri_t = phase_q[31] ? ~tri_u : tri_u;

    raw = '0;
    if (enable) begin
      case (wave_sel)
        2'd0:    raw = phase_q[31] ? -c_sample_max : c_sample_max;
        2'd1:    raw = {~phase_q[31], phase_q[30:32-SAMPLE_WIDTH]};
        2'd2:    raw = {~tri_t[SAMPLE_WIDTH-1], tri_t[SAMPLE_WIDTH-2:0]};
        default: raw = '0;
      endcase
    end

    // Product is wide enough that it never overflows; the arithmetic shift floors.
    raw_ext = {{(VOLUME_WIDTH+1){raw[SAMPLE_WIDTH-1]}}, raw};
    vol_ext = {{(SAMPLE_WIDTH+1){1'b0}}, volume};
    scaled  = SAMPLE_WIDTH'((raw_ext * vol_ext) >>> VOLUME_WIDTH);
  end

  always_comb begin
    count_d = tick ? '0 : count_q + c_cnt_w'(1);
    phase_d = phase_q;
    data_d  = data_q;
    valid_d = valid_q;
`ifdef WAVE_TONE_OVERRUN_COUNT_EN
    overrun_count_d = overrun_count_q;
`endif

    if (tick) begin
      // Phase advances even on overrun so pitch is unaffected by back-pressure.
      phase_d = enable ? phase_q + inc : '0;
      if (!valid_q || source_ready) begin
        data_d  = scaled;
        valid_d = 1'b1;
      end
`ifdef WAVE_TONE_OVERRUN_COUNT_EN
      else if (overrun_count_q != 16'hFFFF) begin
        overrun_count_d = overrun_count_q + 16'd1;
      end
`endif
    end else if (valid_q && source_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      phase_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
`ifdef WAVE_TONE_OVERRUN_COUNT_EN
      overrun_count_q <= '0;
`endif
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
      data_q  <= data_d;
      valid_q <= valid_d;
`ifdef WAVE_TONE_OVERRUN_COUNT_EN
      overrun_count_q <= overrun_count_d;
`endif
    end
  end

  assign source_data  = data_q;
  assign source_valid = valid_q;
`ifdef WAVE_TONE_OVERRUN_COUNT_EN
  assign overrun_count = overrun_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wave_tone_generator.sv
// ============================================================================
// tb_wave_tone_generator : scoreboard bench for wave_tone_generator.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_wave_tone_generator;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [3:0]  note;
  logic [2:0]  octave;
  logic [3:0]  volume;
  logic [1:0]  wave_sel;
  logic        source_ready;
  logic [15:0] source_data;
  logic        source_valid;
`ifdef WAVE_TONE_OVERRUN_COUNT_EN
  logic [15:0] overrun_count;
`endif

  always #5 clk = ~clk;

  wave_tone_generator dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .note         (note),
    .octave       (octave),
    .volume       (volume),
    .wave_sel     (wave_sel),
    .source_ready (source_ready),
    .source_data  (source_data),
    .source_valid (source_valid)
`ifdef WAVE_TONE_OVERRUN_COUNT_EN
    ,
    .overrun_count(overrun_count)
`endif
  );

  int          pass_cnt  = 0;
  int          total_cnt = 0;
  logic [31:0] m_phase;
  logic [15:0] exp_q[$];
  time         t_valid;
  real         f0 [12] = '{16.35, 17.32, 18.35, 19.45, 20.60, 21.83,
                           23.12, 24.50, 25.96, 27.50, 29.14, 30.87};

  function automatic logic [31:0] model_inc(int n, int oct);
    int     idx;
    longint base;
    idx  = (n > 11) ? 11 : n;
    base = longint'($rtoi(f0[idx] * 4294967296.0 / 48000.0 + 0.5));
    return 32'(base << oct);
  endfunction

  function automatic int model_sample(logic [31:0] ph, int wave, int vol, bit en);
    int raw;
    int u;
    if (!en) return 0;
    case (wave)
      0:       raw = ph[31] ? -32767 : 32767;
      1:       raw = int'(ph >> 16) - 32768;
      2: begin
        u = int'((ph >> 15) & 32'h0000FFFF);
        if (ph[31]) u = 65535 - u;
        raw = u - 32768;
      end
      default: raw = 0;
    endcase
    return (raw * vol) >>> 4;
  endfunction

  task automatic model_ticks(int n, bit keep);
    for (int i = 0; i < n; i++) begin
      if (keep)
        exp_q.push_back(16'(model_sample(m_phase, int'(wave_sel), int'(volume), enable)));
      m_phase = enable ? m_phase + model_inc(int'(note), int'(octave)) : 32'd0;
    end
  endtask

  task automatic wait_valid(output int cycles, output bit ok);
    cycles = 0;
    ok     = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      cycles++;
      if (source_valid === 1'b1) begin
        ok = 1'b1;
        t_valid = $time;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int cyc; bit ok; logic [15:0] e;
    reset = 1'b1; enable = 1'b1; note = 4'd9; octave = 3'd5; volume = 4'd15;
    wave_sel = 2'd0; source_ready = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (source_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", source_valid);
    else pass_cnt++;
    total_cnt++;
    if (source_data !== 16'h0000) $display("FAIL reset_data: got %h expected 0000", source_data);
    else pass_cnt++;
`ifdef WAVE_TONE_OVERRUN_COUNT_EN
    total_cnt++;
    if (overrun_count !== 16'd0) $display("FAIL reset_overrun: got %0d expected 0", overrun_count);
    else pass_cnt++;
`endif
    exp_q.delete();
    m_phase = 32'd0;
    reset = 1'b0;
    model_ticks(1, 1'b1);
    wait_valid(cyc, ok);
    // Tick lands on the 1042nd edge after release; valid is seen right after it.
    total_cnt++;
    if (!ok || cyc != 1042) $display("FAIL first_tick_latency: got %0d cycles expected 1042", cyc);
    else pass_cnt++;
    e = exp_q.pop_front();
    total_cnt++;
    if (source_data !== e) $display("FAIL reset_sample0: got %0d expected %0d", $signed(source_data), $signed(e));
    else pass_cnt++;
  endtask

  task automatic test_square();
    int cyc; bit ok; logic [15:0] e; time t_prev;
    model_ticks(28, 1'b1);
    for (int i = 1; i <= 28; i++) begin
      t_prev = t_valid;
      wait_valid(cyc, ok);
      e = exp_q.pop_front();
      total_cnt++;
      if (!ok || source_data !== e)
        $display("FAIL square_sample%0d: got %0d expected %0d", i, $signed(source_data), $signed(e));
      else pass_cnt++;
      total_cnt++;
      if (t_valid - t_prev != 64'd10420)
        $display("FAIL square_cadence%0d: got %0t expected 10420ns", i, t_valid - t_prev);
      else pass_cnt++;
      if (i == 27) begin
        total_cnt++;
        if (source_data !== 16'h77FF) $display("FAIL square_last_pos: got %h expected 77ff", source_data);
        else pass_cnt++;
      end
      if (i == 28) begin
        total_cnt++;
        if (source_data !== 16'h8800) $display("FAIL square_first_neg: got %h expected 8800", source_data);
        else pass_cnt++;
      end
      @(negedge clk);
      total_cnt++;
      if (source_valid !== 1'b0) $display("FAIL square_pulse%0d: got valid %b expected 0", i, source_valid);
      else pass_cnt++;
    end
  endtask

  task automatic test_saw();
    int cyc; bit ok; logic [15:0] e;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    m_phase = 32'd0;
    wave_sel = 2'd1; octave = 3'd7;
    model_ticks(15, 1'b1);
    for (int i = 0; i < 15; i++) begin
      wait_valid(cyc, ok);
      e = exp_q.pop_front();
      total_cnt++;
      if (!ok || source_data !== e)
        $display("FAIL saw_sample%0d: got %0d expected %0d", i, $signed(source_data), $signed(e));
      else pass_cnt++;
      if (i == 0) begin
        total_cnt++;
        if (source_data !== 16'h8800) $display("FAIL saw_phase0: got %h expected 8800", source_data);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_overrun();
    int cyc; bit ok; bit stable; logic [15:0] e; logic [15:0] held;
    @(negedge clk);
    source_ready = 1'b0;
    model_ticks(1, 1'b1);
    model_ticks(1, 1'b0);
    wait_valid(cyc, ok);
    e = exp_q.pop_front();
    total_cnt++;
    if (!ok || source_data !== e)
      $display("FAIL overrun_first: got %0d expected %0d", $signed(source_data), $signed(e));
    else pass_cnt++;
    held = e;
    stable = 1'b1;
    repeat (1052) begin
      @(negedge clk);
      if (source_valid !== 1'b1 || source_data !== held) stable = 1'b0;
    end
    total_cnt++;
    if (!stable) $display("FAIL overrun_hold: got valid %b data %h expected 1 %h", source_valid, source_data, held);
    else pass_cnt++;
`ifdef WAVE_TONE_OVERRUN_COUNT_EN
    total_cnt++;
    if (overrun_count !== 16'd1) $display("FAIL overrun_count: got %0d expected 1", overrun_count);
    else pass_cnt++;
`endif
    source_ready = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (source_valid !== 1'b0) $display("FAIL overrun_release: got valid %b expected 0", source_valid);
    else pass_cnt++;
  endtask

  task automatic test_clamp();
    int cyc; bit ok; logic [15:0] e;
    note = 4'd13; octave = 3'd0; wave_sel = 2'd1; volume = 4'd15;
    model_ticks(3, 1'b1);
    for (int i = 0; i < 3; i++) begin
      wait_valid(cyc, ok);
      e = exp_q.pop_front();
      total_cnt++;
      if (!ok || source_data !== e)
        $display("FAIL clamp_sample%0d: got %0d expected %0d", i, $signed(source_data), $signed(e));
      else pass_cnt++;
    end
  endtask

  task automatic test_silence();
    int cyc; bit ok; logic [15:0] e;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) begin
        note = 4'd9; octave = 3'd5; wave_sel = 2'd0; volume = 4'd0;
      end else begin
        wave_sel = 2'd3; volume = 4'd15;
      end
      model_ticks(2, 1'b1);
      for (int i = 0; i < 2; i++) begin
        wait_valid(cyc, ok);
        e = exp_q.pop_front();
        total_cnt++;
        if (!ok || source_data !== e)
          $display("FAIL silence%0d_sample%0d: got %0d expected %0d", pass, i, $signed(source_data), $signed(e));
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_enable();
    int cyc; bit ok; logic [15:0] e;
    for (int pass = 0; pass < 2; pass++) begin
      enable = (pass == 1);
      wave_sel = 2'd2;
      model_ticks(2, 1'b1);
      for (int i = 0; i < 2; i++) begin
        wait_valid(cyc, ok);
        e = exp_q.pop_front();
        total_cnt++;
        if (!ok || source_data !== e)
          $display("FAIL enable%0d_sample%0d: got %0d expected %0d", pass, i, $signed(source_data), $signed(e));
        else pass_cnt++;
        if (pass == 1 && i == 0) begin
          total_cnt++;
          if (source_data !== 16'h8800) $display("FAIL reenable_phase0: got %h expected 8800", source_data);
          else pass_cnt++;
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int cyc; bit ok; logic [15:0] e;
    @(negedge clk);
    source_ready = 1'b0;
    model_ticks(1, 1'b1);
    wait_valid(cyc, ok);
    e = exp_q.pop_front();
    total_cnt++;
    if (!ok || source_data !== e)
      $display("FAIL midreset_pre: got %0d expected %0d", $signed(source_data), $signed(e));
    else pass_cnt++;
    repeat (5) @(negedge clk);
    total_cnt++;
    if (source_valid !== 1'b1) $display("FAIL midreset_held: got valid %b expected 1", source_valid);
    else pass_cnt++;
    reset = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (source_valid !== 1'b0 || source_data !== 16'h0000)
      $display("FAIL midreset_clear: got valid %b data %h expected 0 0000", source_valid, source_data);
    else pass_cnt++;
    reset = 1'b0;
    source_ready = 1'b1;
    exp_q.delete();
    m_phase = 32'd0;
    model_ticks(1, 1'b1);
    wait_valid(cyc, ok);
    total_cnt++;
    if (!ok || cyc != 1042) $display("FAIL midreset_latency: got %0d cycles expected 1042", cyc);
    else pass_cnt++;
    e = exp_q.pop_front();
    total_cnt++;
    if (source_data !== e) $display("FAIL midreset_sample: got %0d expected %0d", $signed(source_data), $signed(e));
    else pass_cnt++;
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    t_valid = 0;
    test_reset();
    test_square();
    test_saw();
    test_overrun();
    test_clamp();
    test_silence();
    test_enable();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
